if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
// Instruction-fetch stage: owns the PC, issues requests to instruction memory, and drives
//   the IF/ID register inputs (pc_plus4, instruction, hold).
// Absorbs memory wait states, load-use stalls and branch/jump redirects.
// Discards stale in-flight responses, so IF/ID only ever sees the correct instruction stream.
// PARAMETERS
// RESET_PC   32'h0000_0000   PC loaded on reset
// ADDR_W     32              PC / memory address width (instructions 32-bit, word aligned)
// PORTS
// clk            in   1       rising-edge clock
// reset          in   1       asynchronous, active-high reset
// stall_i        in   1       hazard-unit stall; PC holds, IF/ID also holds
// redirect_i     in   1       branch/jump taken; same cycle the IF/ID register is flushed
// redirect_pc_i  in   ADDR_W  new PC; bits [1:0] ignored (forced 2'b00)
// imem_req_o     out  1       fetch request
// imem_addr_o    out  ADDR_W  fetch address; stable while req high and not yet acked
// imem_ack_i     in   1       one-cycle response strobe; may coincide with first req cycle
// imem_rdata_i   in   32      instruction, valid only when imem_ack_i=1
// instruction_o  out  32      to IF/ID instruction_in
// pc_plus4_o     out  ADDR_W  to IF/ID pc_plus4_in; equals PC of instruction_o + 4
// hold_o         out  1       to IF/ID hold_i; 1 = no new instruction this cycle
// BEHAVIOUR
// - Registers: pc, req_addr, buf_valid, buf_instr, state {FETCH, DROP}.
// - Reset (async): pc=RESET_PC, state=FETCH, buf_valid=0, buf_instr=0.
//   - While reset is high: imem_req_o=0, hold_o=1, instruction_o=0.
// - avail = buf_valid | (state==FETCH & imem_ack_i).
//   - instruction_o = buf_valid ? buf_instr : imem_rdata_i (0 if !avail).
//   - pc_plus4_o = pc+4, mod 2^ADDR_W: wraps 32'hFFFF_FFFC -> 32'h0.
//   - hold_o = ~avail. All three outputs are combinational; IF/ID adds the one-cycle latency.
// - FETCH: imem_req_o = ~buf_valid; imem_addr_o = pc; req_addr <= pc each cycle req is high.
// - Priority per cycle: redirect_i > stall_i > normal advance.
//   - redirect_i:
//     - pc <= {redirect_pc_i[ADDR_W-1:2],2'b00}; buf_valid <= 0.
//     - If a request is outstanding and imem_ack_i=0: state <= DROP.
//     - An ack in the same cycle completes that request; its data is discarded.
//   - stall_i & avail: pc holds.
//     - If !buf_valid, buf_instr <= imem_rdata_i and buf_valid <= 1 (skid capture).
//     - No new request while buf_valid.
//   - avail & ~stall_i: pc <= pc+4, buf_valid <= 0; the next request issues the following cycle.
//   - no ack & no buf: req stays high, address held (memory wait state); hold_o=1.
// - DROP: imem_req_o=1, imem_addr_o=req_addr (old address), hold_o=1.
//   - On imem_ack_i: data discarded, state <= FETCH.
//   - A further redirect in DROP only updates pc.
// - Never more than one outstanding request; req never deasserted before ack except via reset.
// - Reset mid-request abandons it; the memory is reset by the same signal.
// STRUCTURE
// - Shared package cpu_pkg: RESET_PC default, INSTR_W=32, fetch_state_t enum {FETCH, DROP},
//   NOP encoding 32'h0.
// - One sub-module: fetch_skid_buf (buf_valid/buf_instr capture and release logic).
// - PC, FSM and output muxing remain in if_fetch_unit.
// TESTING
// 1 Zero-wait memory (ack same cycle as req), no stalls, from reset:
//   -> addresses 0,4,8,C on consecutive cycles; pc_plus4_o 4,8,C,10; hold_o=0 every cycle.
// 2 Memory with 2 wait cycles at addr 0x10:
//   -> req held, addr 0x10 stable 3 cycles, hold_o=1 for 2 cycles, then instr presented once.
// 3 stall_i high 3 cycles, ack arriving in first stall cycle (data 32'hDEAD_BEEF):
//   -> no new req during the stall.
//   -> After release, instruction_o = 32'hDEAD_BEEF with hold_o=0, then next address issued.
// 4 redirect_i to 0x200 while fetch of 0x14 waits unacked:
//   -> DROP, addr stays 0x14 until ack, data dropped (hold_o=1).
//   -> Next req addr=0x200, pc_plus4_o=0x204.
// 5 redirect_i and stall_i together, redirect_pc_i = 0x103:
//   -> redirect wins; next fetch addr 0x100; buffered instr discarded.
// 6 Async reset asserted mid-wait at pc=0x40, released off-edge:
//   -> req drops immediately; first fetch after release is RESET_PC.
//   -> Also check pc wrap: 0xFFFF_FFFC -> pc_plus4_o=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction width and reset/NOP constants.
package cpu_pkg;

   localparam int          INSTR_W      = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP          = 32'h0000_0000;

   typedef enum logic {
      FETCH = 1'b0,
      DROP  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction that arrived while the pipeline was stalled.
module fetch_skid_buf
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               capture,
   input  logic               clear,
   input  logic [INSTR_W-1:0] data,
   output logic               buf_valid,
   output logic [INSTR_W-1:0] buf_instr
);

   // A clear (advance or redirect) always wins over a capture in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_valid <= 1'b0;
         buf_instr <= NOP;
      end else if (clear) begin
         buf_valid <= 1'b0;
      end else if (capture) begin
         buf_valid <= 1'b1;
         buf_instr <= data;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests and
// feeds IF/ID, absorbing wait states, stalls and redirects (stale responses are dropped).
module if_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF[ADDR_W-1:0]
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [ADDR_W-1:0]  redirect_pc_i,
   output logic               imem_req_o,
   output logic [ADDR_W-1:0]  imem_addr_o,
   input  logic               imem_ack_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic [INSTR_W-1:0] instruction_o,
   output logic [ADDR_W-1:0]  pc_plus4_o,
   output logic               hold_o
);

   fetch_state_t       state, state_nxt;
   logic [ADDR_W-1:0]  pc, pc_nxt, req_addr, redirect_tgt, pc_inc;
   logic               buf_valid;
   logic [INSTR_W-1:0] buf_instr;
   logic               avail, req_raw, capture, clear;

   assign redirect_tgt = redirect_pc_i & ~ADDR_W'(3);
   assign pc_inc       = pc + ADDR_W'(4);

   // In DROP the abandoned request must stay up until its ack retires it.
   assign req_raw = (state == DROP) | ~buf_valid;
   assign avail   = buf_valid | ((state == FETCH) & imem_ack_i);

   assign imem_req_o    = ~reset & req_raw;
   assign imem_addr_o   = (state == DROP) ? req_addr : pc;
   assign pc_plus4_o    = pc_inc;
   assign hold_o        = reset | ~avail;
   assign instruction_o = reset     ? NOP :
                          buf_valid ? buf_instr :
                          avail     ? imem_rdata_i : NOP;

   assign capture = (state == FETCH) & ~redirect_i & stall_i & imem_ack_i & ~buf_valid;
   assign clear   = redirect_i | (avail & ~stall_i);

   fetch_skid_buf u_skid (
      .clk       (clk),
      .reset     (reset),
      .capture   (capture),
      .clear     (clear),
      .data      (imem_rdata_i),
      .buf_valid (buf_valid),
      .buf_instr (buf_instr)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if ((state == FETCH) && req_raw) req_addr <= pc;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      case (state)
         FETCH: begin
            if (redirect_i) begin
               pc_nxt = redirect_tgt;
               // An ack this same cycle completes the request, so nothing is left to drop.
               if (req_raw && !imem_ack_i) state_nxt = DROP;
            end else if (avail && !stall_i) begin
               pc_nxt = pc_inc;
            end
         end
         DROP: begin
            if (imem_ack_i) state_nxt = FETCH;
            if (redirect_i) pc_nxt = redirect_tgt;
         end
         default: state_nxt = FETCH;
      endcase
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed scenarios plus randomized traffic checked against an instruction-stream model.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i, redirect_i, imem_ack_i;
   logic [31:0] redirect_pc_i, imem_rdata_i;
   logic        imem_req_o, hold_o;
   logic [31:0] imem_addr_o, instruction_o, pc_plus4_o;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] JUNK = 32'hBAD0_C0DE;

   // random-phase model state
   logic        busy;
   int          wcnt;
   logic [31:0] maddr, exp_pc;
   int          hold_run;
   logic        st, rd;
   logic [31:0] rpc;

   if_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_rdata_i  (imem_rdata_i),
      .instruction_o (instruction_o),
      .pc_plus4_o    (pc_plus4_o),
      .hold_o        (hold_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic s, input logic r, input logic [31:0] rp,
                      input logic ak, input logic [31:0] dat);
      @(negedge clk);
      stall_i = s; redirect_i = r; redirect_pc_i = rp; imem_ack_i = ak; imem_rdata_i = dat;
      #1;
   endtask

   task automatic expo(input string t, input logic req, input logic [31:0] addr,
                       input logic hold, input logic [31:0] p4, input logic [31:0] ins);
      chk({t, ".req"}, {31'b0, imem_req_o}, {31'b0, req});
      if (req) chk({t, ".addr"}, imem_addr_o, addr);
      chk({t, ".hold"}, {31'b0, hold_o}, {31'b0, hold});
      chk({t, ".pc4"}, pc_plus4_o, p4);
      chk({t, ".instr"}, instruction_o, ins);
   endtask

   initial begin
      reset = 1'b1; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
      imem_ack_i = 0; imem_rdata_i = 0;
      #3;
      chk("rst.req", {31'b0, imem_req_o}, 32'd0);
      chk("rst.hold", {31'b0, hold_o}, 32'd1);
      chk("rst.instr", instruction_o, 32'd0);
      #9 reset = 1'b0;

      // zero-wait streaming
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 1, memf(32'(4 * i)));
         expo("t1", 1, 32'(4 * i), 0, 32'(4 * i + 4), memf(32'(4 * i)));
      end

      // two wait states at 0x10
      repeat (2) begin
         cyc(0, 0, 0, 0, JUNK);
         expo("t2w", 1, 32'h10, 1, 32'h14, 32'h0);
      end
      cyc(0, 0, 0, 1, memf(32'h10));
      expo("t2a", 1, 32'h10, 0, 32'h14, memf(32'h10));

      // redirect while 0x14 waits -> drop stale response
      cyc(0, 1, 32'h200, 0, JUNK);
      expo("t4r", 1, 32'h14, 1, 32'h18, 32'h0);
      cyc(0, 0, 0, 0, JUNK);
      expo("t4d", 1, 32'h14, 1, 32'h204, 32'h0);
      cyc(0, 0, 0, 1, JUNK);
      expo("t4x", 1, 32'h14, 1, 32'h204, 32'h0);
      cyc(0, 0, 0, 1, memf(32'h200));
      expo("t4n", 1, 32'h200, 0, 32'h204, memf(32'h200));

      // stall with ack on the first stalled cycle
      cyc(1, 0, 0, 1, 32'hDEAD_BEEF);
      expo("t3a", 1, 32'h204, 0, 32'h208, 32'hDEAD_BEEF);
      repeat (2) begin
         cyc(1, 0, 0, 0, JUNK);
         expo("t3s", 0, 32'h0, 0, 32'h208, 32'hDEAD_BEEF);
      end
      cyc(0, 0, 0, 0, JUNK);
      expo("t3r", 0, 32'h0, 0, 32'h208, 32'hDEAD_BEEF);

      // redirect beats stall; buffered instruction discarded
      cyc(1, 0, 0, 1, memf(32'h208));
      expo("t5c", 1, 32'h208, 0, 32'h20C, memf(32'h208));
      cyc(1, 1, 32'h103, 0, JUNK);
      expo("t5r", 0, 32'h0, 0, 32'h20C, memf(32'h208));
      cyc(0, 0, 0, 0, JUNK);
      expo("t5n", 1, 32'h100, 1, 32'h104, 32'h0);
      cyc(0, 0, 0, 1, memf(32'h100));
      expo("t5a", 1, 32'h100, 0, 32'h104, memf(32'h100));

      // async reset mid-wait at 0x40
      cyc(0, 1, 32'h40, 1, memf(32'h104));
      expo("t6r", 1, 32'h104, 0, 32'h108, memf(32'h104));
      cyc(0, 0, 0, 0, JUNK);
      expo("t6w", 1, 32'h40, 1, 32'h44, 32'h0);
      #2 reset = 1'b1; imem_ack_i = 0;
      #1;
      chk("t6.req", {31'b0, imem_req_o}, 32'd0);
      chk("t6.hold", {31'b0, hold_o}, 32'd1);
      chk("t6.instr", instruction_o, 32'd0);
      chk("t6.pc4", pc_plus4_o, 32'h4);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      cyc(0, 0, 0, 1, memf(32'h0));
      expo("t6a", 1, 32'h0, 0, 32'h4, memf(32'h0));

      // PC wrap at top of address space
      cyc(0, 1, 32'hFFFF_FFFF, 1, memf(32'h4));
      expo("wr0", 1, 32'h4, 0, 32'h8, memf(32'h4));
      cyc(0, 0, 0, 0, JUNK);
      expo("wr1", 1, 32'hFFFF_FFFC, 1, 32'h0, 32'h0);
      cyc(0, 0, 0, 1, memf(32'hFFFF_FFFC));
      expo("wr2", 1, 32'hFFFF_FFFC, 0, 32'h0, memf(32'hFFFF_FFFC));
      cyc(0, 0, 0, 1, memf(32'h0));
      expo("wr3", 1, 32'h0, 0, 32'h4, memf(32'h0));

      // randomized traffic vs. expected instruction stream
      @(negedge clk);
      stall_i = 0; redirect_i = 0; imem_ack_i = 0;
      reset = 1'b1;
      @(negedge clk);
      #2 reset = 1'b0;
      busy = 0; wcnt = 0; maddr = 0; exp_pc = 0; hold_run = 0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         st  = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 9) == 0);
         rpc = $urandom & 32'h0000_0FFF;
         chk("r.req_held", {31'b0, imem_req_o | ~busy}, 32'd1);
         imem_rdata_i = $urandom;
         imem_ack_i   = 1'b0;
         if (imem_req_o) begin
            if (!busy) begin
               chk("r.start_addr", imem_addr_o, exp_pc);
               busy  = 1'b1;
               wcnt  = $urandom_range(0, 3);
               maddr = imem_addr_o;
            end else begin
               chk("r.addr_stable", imem_addr_o, maddr);
            end
            if (wcnt == 0) begin
               imem_ack_i   = 1'b1;
               imem_rdata_i = memf(maddr);
               busy         = 1'b0;
            end else begin
               wcnt--;
            end
         end
         stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
         #1;
         chk("r.pc4", pc_plus4_o, exp_pc + 32'd4);
         if (!hold_o && !rd) chk("r.instr", instruction_o, memf(exp_pc));
         hold_run = hold_o ? hold_run + 1 : 0;
         chk("r.live", {31'b0, (hold_run > 12)}, 32'd0);
         if (rd) exp_pc = rpc & ~32'd3;
         else if (!hold_o && !st) exp_pc = exp_pc + 32'd4;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
